// File: rtl/test_pattern_gen_multi.sv
`timescale 1ns / 1ps
// test_pattern_gen_multi
//   Parametrised video test pattern source with internal raster timing.
//   Patterns are colour bars, checkerboard, horizontal ramp and a moving box.
//   The pattern mode is latched only at the frame boundary.
//
// Ports:
//   pixel_clock       - pixel clock, all logic on the rising edge
//   reset_n           - asynchronous active-low reset
//   pattern_mode      - 0 bars, 1 checker, 2 ramp, 3 moving box
//   video_hsync       - horizontal sync, active level HSYNC_POL
//   video_vsync       - vertical sync, active level VSYNC_POL
//   video_den         - data enable
//   video_line_start  - pulse on the first active pixel of each active line
//   video_frame_start - pulse on the first active pixel of each frame
//   video_pixel       - {R,G,B}, zero while den is low
//   frame_count       - completed-frame counter
module test_pattern_gen_multi #(
  parameter int unsigned H_LENGTH    = 800,
  parameter int unsigned V_LENGTH    = 525,
  parameter bit          HSYNC_POL   = 1'b0,
  parameter int unsigned HSYNC_LEN   = 96,
  parameter int unsigned HBP_LEN     = 48,
  parameter int unsigned H_VISIBLE   = 640,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int unsigned VSYNC_LEN   = 2,
  parameter int unsigned VBP_LEN     = 33,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned COLOUR_BITS = 8,
  parameter int unsigned NUM_BARS    = 16,
  parameter int unsigned CHECK_LOG2  = 5,
  parameter int unsigned BOX_SIZE    = 64
) (
  input  logic                       pixel_clock,
  input  logic                       reset_n,
  input  logic [1:0]                 pattern_mode,
  output logic                       video_hsync,
  output logic                       video_vsync,
  output logic                       video_den,
  output logic                       video_line_start,
  output logic                       video_frame_start,
  output logic [3*COLOUR_BITS-1:0]   video_pixel,
  output logic [15:0]                frame_count
);

  localparam int unsigned HW      = $clog2(H_LENGTH);
  localparam int unsigned VW      = $clog2(V_LENGTH);
  localparam int unsigned HS      = HSYNC_LEN + HBP_LEN;
  localparam int unsigned VS      = VSYNC_LEN + VBP_LEN;
  localparam int unsigned BY      = (V_VISIBLE - BOX_SIZE) / 2;
  localparam int unsigned BOX_MAX = H_VISIBLE - BOX_SIZE;
  localparam int unsigned CB      = COLOUR_BITS;
  localparam int unsigned REP     = COLOUR_BITS / 2;

  // Raster counters and frame-level state
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          started_q;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [HW-1:0] box_x_q, box_x_d;

  // Registered outputs
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          den_q, den_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [3*CB-1:0] pixel_q, pixel_d;

  // Decode done in 32 bits so that HS+H_VISIBLE == 2**HW cannot wrap
  logic [31:0] h_ext, v_ext, x, y, box_ext;
  logic        hact, vact, den, frame_evt, h_last, v_last;

  assign h_ext   = 32'(h_q);
  assign v_ext   = 32'(v_q);
  assign box_ext = 32'(box_x_q);
  assign x       = h_ext - HS;
  assign y       = v_ext - VS;

  assign hact      = (h_ext >= HS) && (h_ext < HS + H_VISIBLE);
  assign vact      = (v_ext >= VS) && (v_ext < VS + V_VISIBLE);
  assign den       = hact && vact;
  assign h_last    = (h_ext == H_LENGTH - 1);
  assign v_last    = (v_ext == V_LENGTH - 1);
  assign frame_evt = (h_q == '0) && (v_q == '0);

  // Counters and frame-boundary state
  always_comb begin
    h_d           = h_q + HW'(1);
    v_d           = v_q;
    mode_d        = mode_q;
    frame_count_d = frame_count_q;
    box_x_d       = box_x_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + VW'(1);
    end
    if (frame_evt) begin
      mode_d = pattern_mode;
      // The boundary seen on the very first clock after reset is not a completed frame
      if (started_q) begin
        frame_count_d = frame_count_q + 16'd1;
        box_x_d       = (box_ext == BOX_MAX) ? '0 : box_x_q + HW'(1);
      end
    end
  end

  // Pattern generation
  logic [3:0]    bar_idx;
  logic [5:0]    bar_lvl;
  logic [CB-1:0] ramp;
  logic          in_box;
  logic [3*CB-1:0] pattern;

  assign bar_idx = 4'((x * NUM_BARS) / H_VISIBLE);
  assign ramp    = CB'((x << COLOUR_BITS) / H_VISIBLE);
  assign in_box  = (x >= box_ext) && (x < box_ext + BOX_SIZE) &&
                   (y >= BY) && (y < BY + BOX_SIZE);

  // Bar table as {R,G,B} 2-bit levels: 3 = full, 2 = 2/3, 1 = 1/3, 0 = off
  always_comb begin
    bar_lvl = 6'b00_00_00;
    unique case (bar_idx)
      4'd0:  bar_lvl = 6'b11_00_00;
      4'd1:  bar_lvl = 6'b00_11_00;
      4'd2:  bar_lvl = 6'b00_00_11;
      4'd3:  bar_lvl = 6'b11_11_11;
      4'd4:  bar_lvl = 6'b10_00_00;
      4'd5:  bar_lvl = 6'b00_10_00;
      4'd6:  bar_lvl = 6'b00_00_10;
      4'd7:  bar_lvl = 6'b10_10_10;
      4'd8:  bar_lvl = 6'b01_00_00;
      4'd9:  bar_lvl = 6'b00_01_00;
      4'd10: bar_lvl = 6'b00_00_01;
      4'd11: bar_lvl = 6'b01_01_01;
      4'd12: bar_lvl = 6'b11_11_00;
      4'd13: bar_lvl = 6'b11_00_11;
      4'd14: bar_lvl = 6'b00_11_11;
      4'd15: bar_lvl = 6'b00_00_00;
    endcase
  end

  always_comb begin
    pattern = '0;
    unique case (mode_q)
      2'd0: pattern = {{REP{bar_lvl[5:4]}}, {REP{bar_lvl[3:2]}}, {REP{bar_lvl[1:0]}}};
      2'd1: if (x[CHECK_LOG2] ^ y[CHECK_LOG2]) pattern = '1;
      2'd2: pattern = {ramp, ramp, ramp};
      2'd3: if (in_box) pattern = '1;
    endcase
  end

  // Output decode; registered so every output lines up one clock after the counters
  always_comb begin
    hsync_d       = (h_ext < HSYNC_LEN) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = (v_ext < VSYNC_LEN) ? VSYNC_POL : ~VSYNC_POL;
    den_d         = den;
    line_start_d  = den && (x == 32'd0);
    frame_start_d = den && (x == 32'd0) && (y == 32'd0);
    pixel_d       = den ? pattern : '0;
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q           <= '0;
      v_q           <= '0;
      started_q     <= 1'b0;
      mode_q        <= 2'd0;
      frame_count_q <= 16'd0;
      box_x_q       <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      den_q         <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_q       <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      started_q     <= 1'b1;
      mode_q        <= mode_d;
      frame_count_q <= frame_count_d;
      box_x_q       <= box_x_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      den_q         <= den_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      pixel_q       <= pixel_d;
    end
  end

  assign video_hsync       = hsync_q;
  assign video_vsync       = vsync_q;
  assign video_den         = den_q;
  assign video_line_start  = line_start_q;
  assign video_frame_start = frame_start_q;
  assign video_pixel       = pixel_q;
  assign frame_count       = frame_count_q;

endmodule
